// File: rtl/ypc_pkg.sv
// Shared constants and types for the ypc_ctrl PC/control sequencer.
package ypc_pkg;

   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_OPIMM  = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem2reg;
      logic [2:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

   // Offsets from yID are in words; scale to bytes and wrap at 32 bits.
   function automatic logic [31:0] word_offset(input logic [31:0] base, input logic [31:0] off);
      return base + {off[29:0], 2'b00};
   endfunction

endpackage

// File: rtl/ypc_decode.sv
// Combinational opcode decoder: instruction word to control bundle and class flags.
module ypc_decode
   import ypc_pkg::*;
(
   input  logic [31:0] ir,
   output ctrl_t       ctrl,
   output logic        is_branch,
   output logic        is_jal,
   output logic        is_legal
);

   logic unused_ir_s;

   // Only the opcode, funct3 and bit 30 steer decode.
   always_comb begin
      unused_ir_s = ^{ir[31], ir[29:15], ir[11:7]};
   end

   // Opcode table; anything unrecognised decodes as a NOP and is flagged illegal.
   always_comb begin
      ctrl      = CTRL_NOP;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_legal  = 1'b1;
      case (ir[6:0])
         OP_R: begin
            ctrl.reg_write = 1'b1;
            case (ir[14:12])
               3'b000:  ctrl.alu_op = ir[30] ? ALU_SUB : ALU_ADD;
               3'b110:  ctrl.alu_op = ALU_OR;
               3'b111:  ctrl.alu_op = ALU_AND;
               default: ctrl.alu_op = ALU_ADD;
            endcase
         end
         OP_LOAD: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.mem2reg   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_OPIMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         OP_BRANCH: begin
            ctrl.alu_op = ALU_SUB;
            is_branch   = 1'b1;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            is_jal         = 1'b1;
         end
         default: begin
            is_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ypc_ctrl.sv
// PC register and fetch/exec/commit sequencer driving yIF and the datapath controls.
module ypc_ctrl
   import ypc_pkg::*;
#(
   parameter logic [31:0] ENTRY     = 32'h28,
   parameter int unsigned MAX_INSNS = 43
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] ins,
   input  logic [31:0] pcp4,
   input  logic [31:0] imm,
   input  logic [31:0] jtarget,
   input  logic        zero,
   output logic [31:0] pc,
   output logic        reg_write,
   output logic        mem_write,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem2reg,
   output logic [2:0]  alu_op,
   output logic [15:0] insn_count,
   output logic        illegal,
   output logic        done
);

   state_t      state_r;
   logic [31:0] ir_r;
   logic [31:0] dec_in_s;
   ctrl_t       dec_ctrl_s;
   logic        dec_branch_s;
   logic        dec_jal_s;
   logic        dec_legal_s;
   logic [31:0] next_pc_s;
   logic [15:0] count_inc_s;
   logic        halt_s;

   // Decode the incoming word during FETCH so controls land on the FETCH->EXEC edge.
   always_comb begin
      dec_in_s = (state_r == ST_FETCH) ? ins : ir_r;
   end

   ypc_decode u_decode (
      .ir        (dec_in_s),
      .ctrl      (dec_ctrl_s),
      .is_branch (dec_branch_s),
      .is_jal    (dec_jal_s),
      .is_legal  (dec_legal_s)
   );

   // Next-PC selection, count saturation and halt condition for the COMMIT edge.
   always_comb begin
      next_pc_s = pcp4;
      if (dec_branch_s && zero) begin
         next_pc_s = word_offset(pc, imm);
      end else if (dec_jal_s) begin
         next_pc_s = word_offset(pc, jtarget);
      end else begin
         next_pc_s = pcp4;
      end
      count_inc_s = (insn_count == 16'hFFFF) ? insn_count : insn_count + 16'd1;
      halt_s      = (MAX_INSNS != 32'd0) && (32'(count_inc_s) == MAX_INSNS);
   end

   // Sequencer FSM with registered PC, controls and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         ir_r       <= 32'h0;
         pc         <= ENTRY;
         reg_write  <= 1'b0;
         mem_write  <= 1'b0;
         alu_src    <= 1'b0;
         mem_read   <= 1'b0;
         mem2reg    <= 1'b0;
         alu_op     <= 3'b000;
         insn_count <= 16'h0;
         illegal    <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= start ? ST_FETCH : ST_IDLE;
            end
            ST_FETCH: begin
               ir_r     <= ins;
               alu_src  <= dec_ctrl_s.alu_src;
               mem_read <= dec_ctrl_s.mem_read;
               mem2reg  <= dec_ctrl_s.mem2reg;
               alu_op   <= dec_ctrl_s.alu_op;
               state_r  <= ST_EXEC;
            end
            ST_EXEC: begin
               reg_write <= dec_ctrl_s.reg_write;
               mem_write <= dec_ctrl_s.mem_write;
               state_r   <= ST_COMMIT;
            end
            ST_COMMIT: begin
               pc         <= next_pc_s;
               insn_count <= count_inc_s;
               illegal    <= illegal | ~dec_legal_s;
               reg_write  <= 1'b0;
               mem_write  <= 1'b0;
               alu_src    <= 1'b0;
               mem_read   <= 1'b0;
               mem2reg    <= 1'b0;
               alu_op     <= 3'b000;
               done       <= halt_s;
               state_r    <= halt_s ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
               state_r <= ST_HALT;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ypc_ctrl.sv
// Self-checking bench for ypc_ctrl: directed cases plus random instructions against a behavioural model.
module tb_ypc_ctrl;

   localparam logic [31:0] ENTRY = 32'h28;
   localparam int          MAXN  = 43;

   logic        clk = 1'b0;
   logic        rst_n, start, zero;
   logic [31:0] ins, pcp4, imm, jtarget;

   logic [31:0] a_pc, h_pc;
   logic        a_rw, a_mw, a_as, a_mr, a_m2r, a_ill, a_done;
   logic        h_rw, h_mw, h_as, h_mr, h_m2r, h_ill, h_done;
   logic [2:0]  a_op, h_op;
   logic [15:0] a_cnt, h_cnt;
   logic [7:0]  a_ctrl, h_ctrl;

   assign a_ctrl = {a_rw, a_mw, a_as, a_mr, a_m2r, a_op};
   assign h_ctrl = {h_rw, h_mw, h_as, h_mr, h_m2r, h_op};

   always #5 clk = ~clk;

   ypc_ctrl #(.ENTRY(ENTRY), .MAX_INSNS(MAXN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .pcp4(pcp4), .imm(imm),
      .jtarget(jtarget), .zero(zero), .pc(a_pc), .reg_write(a_rw), .mem_write(a_mw),
      .alu_src(a_as), .mem_read(a_mr), .mem2reg(a_m2r), .alu_op(a_op),
      .insn_count(a_cnt), .illegal(a_ill), .done(a_done));

   ypc_ctrl #(.ENTRY(ENTRY), .MAX_INSNS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .pcp4(pcp4), .imm(imm),
      .jtarget(jtarget), .zero(zero), .pc(h_pc), .reg_write(h_rw), .mem_write(h_mw),
      .alu_src(h_as), .mem_read(h_mr), .mem2reg(h_m2r), .alu_op(h_op),
      .insn_count(h_cnt), .illegal(h_ill), .done(h_done));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_pc, m4_pc;
   int          m_cnt, m4_cnt;
   logic        m_ill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected controls {reg_write, mem_write, alu_src, mem_read, mem2reg, alu_op[2:0]}.
   function automatic logic [7:0] ref_ctrl(input logic [31:0] i);
      logic rw, mw, as, mr, m2r;
      logic [2:0] op;
      logic [2:0] f3;
      rw = 1'b0; mw = 1'b0; as = 1'b0; mr = 1'b0; m2r = 1'b0; op = 3'b000;
      f3 = i[14:12];
      case (i[6:0])
         7'h33: begin
            rw = 1'b1;
            if (f3 == 3'b110)                 op = 3'b001;
            else if (f3 == 3'b111)            op = 3'b000;
            else if (f3 == 3'b000 && i[30])   op = 3'b110;
            else                              op = 3'b010;
         end
         7'h03: begin rw = 1'b1; as = 1'b1; mr = 1'b1; m2r = 1'b1; op = 3'b010; end
         7'h13: begin rw = 1'b1; as = 1'b1; op = 3'b010; end
         7'h23: begin mw = 1'b1; as = 1'b1; op = 3'b010; end
         7'h63: begin op = 3'b110; end
         7'h6F: begin rw = 1'b1; as = 1'b1; op = 3'b010; end
         default: begin end
      endcase
      return {rw, mw, as, mr, m2r, op};
   endfunction

   function automatic logic ref_legal(input logic [6:0] opc);
      return (opc == 7'h33) || (opc == 7'h03) || (opc == 7'h13) ||
             (opc == 7'h23) || (opc == 7'h63) || (opc == 7'h6F);
   endfunction

   task automatic model_reset();
      m_pc = ENTRY; m4_pc = ENTRY; m_cnt = 0; m4_cnt = 0; m_ill = 1'b0;
   endtask

   // Entered at a falling edge with both DUTs in FETCH; leaves at the falling edge after COMMIT.
   task automatic do_insn(input logic [31:0] i, input logic [31:0] p4, input logic [31:0] im,
                          input logic [31:0] jt, input logic z);
      logic [7:0]  e;
      logic [31:0] nxt;
      check("fetch_pc", a_pc, m_pc);
      check("fetch_ctrl", a_ctrl, 8'h00);
      ins = i; pcp4 = p4; imm = im; jtarget = jt; zero = z;
      e = ref_ctrl(i);
      @(negedge clk);
      check("exec_ctrl", a_ctrl, e & 8'h3F);
      check("exec_pc", a_pc, m_pc);
      @(negedge clk);
      check("commit_ctrl", a_ctrl, e);
      check("h_commit_we", {h_rw, h_mw}, (m4_cnt < 4) ? e[7:6] : 2'b00);
      if (i[6:0] == 7'h63 && z)  nxt = m_pc + im * 32'd4;
      else if (i[6:0] == 7'h6F)  nxt = m_pc + jt * 32'd4;
      else                       nxt = p4;
      @(negedge clk);
      m_cnt++;
      m_pc = nxt;
      if (!ref_legal(i[6:0])) m_ill = 1'b1;
      if (m4_cnt < 4) begin
         m4_cnt++;
         m4_pc = nxt;
      end
      check("next_pc", a_pc, m_pc);
      check("count", a_cnt, m_cnt);
      check("illegal", a_ill, m_ill);
      check("post_ctrl", a_ctrl, 8'h00);
      check("done", a_done, m_cnt == MAXN);
      check("h_pc", h_pc, m4_pc);
      check("h_count", h_cnt, m4_cnt);
      check("h_done", h_done, m4_cnt == 4);
   endtask

   initial begin
      logic [31:0] r, ri, rimm, rjt;
      logic [6:0]  opc;
      logic [6:0]  optab [7];
      optab = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h7F};

      rst_n = 1'b0; start = 1'b0; ins = 32'h0; pcp4 = 32'h0; imm = 32'h0;
      jtarget = 32'h0; zero = 1'b0;
      model_reset();
      #12;
      check("rst_pc", a_pc, ENTRY);
      check("rst_ctrl", a_ctrl, 8'h00);
      check("rst_count", a_cnt, 32'd0);
      check("rst_flags", {a_ill, a_done}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_pc", a_pc, ENTRY);
      check("idle_ctrl", a_ctrl, 8'h00);
      start = 1'b1;
      @(negedge clk);

      do_insn(32'h00A00093, 32'h2C, 32'h0, 32'h0, 1'b0);
      do_insn(32'h00100113, 32'h40, 32'h5, 32'h9, 1'b1);
      do_insn(32'h00208463, 32'h44, 32'h3, 32'h0, 1'b1);
      do_insn(32'h00100113, 32'h40, 32'h0, 32'h0, 1'b0);
      do_insn(32'h00208463, 32'h44, 32'h3, 32'h0, 1'b0);
      do_insn(32'h00100113, 32'h30, 32'h0, 32'h0, 1'b0);
      do_insn(32'h008000EF, 32'h34, 32'h0, 32'hFFFFFFFE, 1'b0);
      do_insn(32'h0020E1B3, 32'h2C, 32'h0, 32'h0, 1'b1);
      do_insn(32'h402081B3, 32'h30, 32'h0, 32'h0, 1'b0);
      do_insn(32'h0000007F, 32'h34, 32'h0, 32'h0, 1'b0);

      for (int k = 0; k < MAXN - 10; k++) begin
         r = $urandom();
         opc = (r[2:0] == 3'd7) ? r[9:3] : optab[r[2:0]];
         ri = $urandom();
         rimm = $urandom();
         rjt = $urandom();
         do_insn({ri[31:7], opc}, m_pc + 32'd4, rimm, rjt, r[10]);
      end

      for (int k = 0; k < 6; k++) begin
         ins = $urandom();
         @(negedge clk);
         check("halt_pc", a_pc, m_pc);
         check("halt_ctrl", a_ctrl, 8'h00);
         check("halt_state", {a_done, a_cnt}, {1'b1, 16'(MAXN)});
         check("h_halt", {h_done, h_ctrl, h_pc}, {1'b1, 8'h00, m4_pc});
      end

      // Reset while a store sits in COMMIT.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      check("st_fetch_pc", a_pc, ENTRY);
      ins = 32'h00112023; pcp4 = 32'h2C;
      @(negedge clk);
      @(negedge clk);
      check("st_commit_mw", a_mw, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_mw", a_mw, 1'b0);
      check("mid_rst_pc", a_pc, ENTRY);
      check("mid_rst_count", a_cnt, 32'd0);
      check("mid_rst_flags", {a_ill, a_done, h_done}, 3'b000);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", {a_ctrl, a_pc}, {8'h00, ENTRY});
      end
      start = 1'b1;
      @(negedge clk);
      do_insn(32'h00A00093, 32'h2C, 32'h0, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
